// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the interrupt controller.
package int_ctrl_pkg;

  localparam int unsigned ID_W    = 3;
  localparam int unsigned MAX_SRC = 8;
  localparam logic [15:0] DEFAULT_VEC_BASE = 16'h0010;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-first priority encoder over the candidate request vector.
module int_prio_enc
  import int_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid_c,
  output logic [ID_W-1:0]    idx_c
);

  // Scan from the top down so the lowest set index is written last.
  always_comb begin
    valid_c = |req;
    idx_c   = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (req[i]) idx_c = ID_W'(i);
    end
  end

endmodule

// File: rtl/int_controller.sv
// Edge-captured, fixed-priority interrupt controller feeding the processor's
// interrupt input; one request in flight until return-from-interrupt.
module int_controller
  import int_ctrl_pkg::*;
#(
  parameter int unsigned          NUM_SRC   = 4,
  parameter int unsigned          VEC_WIDTH = 16,
  parameter logic [VEC_WIDTH-1:0] VEC_BASE  = VEC_WIDTH'(DEFAULT_VEC_BASE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_SRC-1:0]   irq_src,
  input  logic [NUM_SRC-1:0]   irq_mask,
  input  logic                 ack,
  input  logic                 rti,
  output logic                 int_req,
  output logic [VEC_WIDTH-1:0] int_vec,
  output logic [ID_W-1:0]      int_id,
  output logic [NUM_SRC-1:0]   pending
);

  state_t               state;
  logic [NUM_SRC-1:0]   irq_prev;
  logic [NUM_SRC-1:0]   rise;
  logic [NUM_SRC-1:0]   cand;
  logic [NUM_SRC-1:0]   clr;
  logic                 win_valid;
  logic [ID_W-1:0]      win_idx;
  logic [VEC_WIDTH-1:0] win_vec;

  int_prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio (
    .req     (cand),
    .valid_c (win_valid),
    .idx_c   (win_idx)
  );

  // Keeps following the source levels through reset, so lines already high
  // when reset is released are not mistaken for fresh edges.
  always_ff @(posedge clk) begin
    irq_prev <= irq_src;
  end

  always_comb begin
    rise    = irq_src & ~irq_prev;
    cand    = pending & ~irq_mask;
    win_vec = VEC_WIDTH'(VEC_BASE + (VEC_WIDTH'(win_idx) << 1));
    clr     = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      clr[i] = (state == REQ) && ack && (int_id == ID_W'(i));
    end
  end

  // A new edge on the bit being acknowledged wins over the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr) | rise;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      int_req <= 1'b0;
      int_vec <= '0;
      int_id  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            state   <= REQ;
            int_req <= 1'b1;
            int_id  <= win_idx;
            int_vec <= win_vec;
          end
        end
        REQ: begin
          if (ack) begin
            state   <= SERVICE;
            int_req <= 1'b0;
          end
        end
        SERVICE: begin
          if (rti) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          int_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
